// File: rtl/datatype_unpack_cast_pkg.sv
// Shared definitions for the widening cast: fn opcodes, immediate field
// positions and the lane-mode / lane-count table.
package datatype_unpack_cast_pkg;

    localparam logic [3:0] FN_UP16 = 4'b0011;  // 2 x 16-bit lanes
    localparam logic [3:0] FN_UP8  = 4'b0100;  // 4 x 8-bit lanes
    localparam logic [3:0] FN_UP4  = 4'b0101;  // 8 x 4-bit lanes

    // immediate: [5:0] input fraction bits, [21:16] output fraction bits
    localparam int IMM_IN_FRAC_LSB  = 0;
    localparam int IMM_OUT_FRAC_LSB = 16;
    localparam int FRAC_W           = 6;

    typedef enum logic [1:0] {
        MODE_32 = 2'd0,
        MODE_16 = 2'd1,
        MODE_8  = 2'd2,
        MODE_4  = 2'd3
    } lane_mode_e;

    // Unknown opcodes fall back to a single 32-bit pass lane.
    function automatic lane_mode_e mode_of_fn(input logic [3:0] fn);
        case (fn)
            FN_UP16: mode_of_fn = MODE_16;
            FN_UP8:  mode_of_fn = MODE_8;
            FN_UP4:  mode_of_fn = MODE_4;
            default: mode_of_fn = MODE_32;
        endcase
    endfunction

    // Index of the last lane (lane count - 1).
    function automatic logic [2:0] last_lane(input lane_mode_e m);
        case (m)
            MODE_16: last_lane = 3'd1;
            MODE_8:  last_lane = 3'd3;
            MODE_4:  last_lane = 3'd7;
            default: last_lane = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/datatype_unpack_cast_lane_widen_shift.sv
// lane_widen_shift: combinational lane select, sign-extend and fraction
// realignment shift. Define DCAST_SAT_EN to saturate left-shift overflow
// instead of wrapping.
module lane_widen_shift
    import datatype_unpack_cast_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] word,
    input  logic [1:0]   mode,
    input  logic [2:0]   lane_idx,
    input  logic         shift_left,
    input  logic [5:0]   shift_amt,
    output logic [W-1:0] elem
);

    logic [W-1:0] sel;
    logic [W-1:0] ext;

    // Pick the active lane and sign-extend it to the full element width
    always_comb begin
        sel = '0;
        ext = '0;
        case (lane_mode_e'(mode))
            MODE_16: begin
                sel = word >> {lane_idx[0], 4'b0000};
                ext = {{(W-16){sel[15]}}, sel[15:0]};
            end
            MODE_8: begin
                sel = word >> {lane_idx[1:0], 3'b000};
                ext = {{(W-8){sel[7]}}, sel[7:0]};
            end
            MODE_4: begin
                sel = word >> {lane_idx, 2'b00};
                ext = {{(W-4){sel[3]}}, sel[3:0]};
            end
            default: ext = word;
        endcase
    end

`ifdef DCAST_SAT_EN
    logic [2*W-1:0] wide;
    logic           ovf;

    // Left shift in double width so bits pushed past the sign can be seen;
    // shifts of W or more overflow for any nonzero lane.
    always_comb begin
        wide = {{W{ext[W-1]}}, ext} << shift_amt;
        if (shift_amt >= 6'(W))
            ovf = (ext != '0);
        else
            ovf = (wide[2*W-1:W-1] != {(W+1){ext[W-1]}});
    end
`endif

    // Realign the fraction: left shift widens, arithmetic right shift narrows
    always_comb begin
        elem = '0;
        if (shift_left) begin
`ifdef DCAST_SAT_EN
            if (ovf)
                elem = ext[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            else
                elem = wide[W-1:0];
`else
            elem = ext << shift_amt;
`endif
        end else if (shift_amt >= 6'(W)) begin
            elem = {W{ext[W-1]}};
        end else begin
            elem = $signed(ext) >>> shift_amt;
        end
    end

endmodule

// File: rtl/datatype_unpack_cast.sv
// datatype_unpack_cast: streaming widening cast. Captures one packed word
// per accept and emits one sign-extended, fraction-realigned element per
// cycle. Optional DCAST_SAT_EN saturates left-shift overflow (see
// lane_widen_shift).
module datatype_unpack_cast
    import datatype_unpack_cast_pkg::*;
#(
    parameter int FUNCTION_BITS = 4,
    parameter int BIT_WIDTH     = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BIT_WIDTH-1:0]     in_data,
    input  logic [FUNCTION_BITS-1:0] fn,
    input  logic [31:0]              immediate,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BIT_WIDTH-1:0]     out_data,
    output logic                     out_last
);

    logic                 busy_q,  busy_d;
    logic [2:0]           idx_q,   idx_d;
    logic [BIT_WIDTH-1:0] word_q,  word_d;
    lane_mode_e           mode_q,  mode_d;
    logic                 shl_q,   shl_d;
    logic [5:0]           amt_q,   amt_d;

    logic [FRAC_W-1:0]    in_frac, out_frac;
    logic                 accept;
    logic [BIT_WIDTH-1:0] elem;
    logic                 unused_imm;

    assign in_frac    = immediate[IMM_IN_FRAC_LSB  +: FRAC_W];
    assign out_frac   = immediate[IMM_OUT_FRAC_LSB +: FRAC_W];
    assign unused_imm = ^{immediate[31:22], immediate[15:6]};

    // Handshake outputs: a new word may land on the last-lane handshake
    always_comb begin
        out_valid = busy_q;
        out_last  = busy_q && (idx_q == last_lane(mode_q));
        in_ready  = !busy_q || (out_ready && out_last);
        accept    = in_valid && in_ready;
        out_data  = busy_q ? elem : '0;
    end

    // Next state: capture on accept, otherwise step lanes on each output handshake
    always_comb begin
        busy_d = busy_q;
        idx_d  = idx_q;
        word_d = word_q;
        mode_d = mode_q;
        shl_d  = shl_q;
        amt_d  = amt_q;
        if (accept) begin
            busy_d = 1'b1;
            idx_d  = '0;
            word_d = in_data;
            mode_d = mode_of_fn(fn);
            if (out_frac > in_frac) begin
                shl_d = 1'b1;
                amt_d = out_frac - in_frac;
            end else begin
                shl_d = 1'b0;
                amt_d = in_frac - out_frac;
            end
        end else if (busy_q && out_ready) begin
            if (out_last) begin
                busy_d = 1'b0;
                idx_d  = '0;
            end else begin
                idx_d  = idx_q + 3'd1;
            end
        end
    end

    // Holding registers; reset drops any partial word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= 1'b0;
            idx_q  <= '0;
            word_q <= '0;
            mode_q <= MODE_32;
            shl_q  <= 1'b0;
            amt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            idx_q  <= idx_d;
            word_q <= word_d;
            mode_q <= mode_d;
            shl_q  <= shl_d;
            amt_q  <= amt_d;
        end
    end

    lane_widen_shift #(.W(BIT_WIDTH)) u_lane (
        .word       (word_q),
        .mode       (mode_q),
        .lane_idx   (idx_q),
        .shift_left (shl_q),
        .shift_amt  (amt_q),
        .elem       (elem)
    );

endmodule

// File: tb/tb_datatype_unpack_cast.sv
// Scoreboard bench for datatype_unpack_cast: the driver pushes hand-computed
// elements on accept, a negedge monitor pops and compares on each handshake.
module tb_datatype_unpack_cast;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [3:0]  fn;
    logic [31:0] immediate;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;

    typedef struct {
        logic [31:0] d;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   fire_cnt = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    datatype_unpack_cast dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .fn        (fn),
        .immediate (immediate),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // Monitor: in_ready tracks the last-lane handshake; pop on every output handshake
    always @(negedge clk) begin
        if (reset && out_valid) begin
            chk("in_ready_vs_last", {31'b0, in_ready}, {31'b0, out_ready & out_last});
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    timeout("unexpected_element");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("out_last", {31'b0, out_last}, {31'b0, e.last});
                    fire_cnt++;
                end
            end
        end
    end

    // Drive one word; expected elements are queued when it is accepted
    task automatic send(input logic [3:0] f, input logic [31:0] d,
                        input logic [5:0] fi, input logic [5:0] fo,
                        input logic [31:0] e[8], input int n);
        int k;
        in_valid  = 1'b1;
        fn        = f;
        in_data   = d;
        immediate = {10'b0, fo, 10'b0, fi};
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!in_ready && k < 60);
        if (!in_ready) timeout("in_ready_wait");
        for (int i = 0; i < n; i++) begin
            exp_t x;
            x.d    = e[i];
            x.last = (i == n - 1);
            exp_q.push_back(x);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(posedge clk);
            k++;
        end
        if (exp_q.size() != 0) timeout("drain");
        #1;
    endtask

    initial begin
        logic [31:0] e[8];
        int base, t0, k;

        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_data   = '0;
        fn        = '0;
        immediate = '0;
        #2;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data",  out_data, 32'd0);
        chk("rst_out_last",  {31'b0, out_last}, 32'd0);
        chk("rst_in_ready",  {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // 8->32, fraction 4 -> 8
        e = '{32'hFFFFFFF0, 32'h00000010, 32'h000007F0, 32'hFFFFF800, 0, 0, 0, 0};
        send(4'b0100, 32'h807F01FF, 6'd4, 6'd8, e, 4);
        drain();

        // 16->32, fraction 8 -> 4
        e = '{32'h00000123, 32'hFFFFF800, 0, 0, 0, 0, 0, 0};
        send(4'b0011, 32'h80001234, 6'd8, 6'd4, e, 2);
        drain();

        // Stall on element 1 for three cycles
        e = '{32'hFFFFFFF0, 32'h00000010, 32'h000007F0, 32'hFFFFF800, 0, 0, 0, 0};
        send(4'b0100, 32'h807F01FF, 6'd4, 6'd8, e, 4);
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_out_data",  out_data, 32'h00000010);
            chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
            chk("stall_in_ready",  {31'b0, in_ready}, 32'd0);
            chk("stall_out_last",  {31'b0, out_last}, 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();

        // Two 4-bit words back to back: 16 elements in 16 cycles
        e = '{32'h5, 32'h1, 32'h7, 32'h3, 32'hFFFFFFFA, 32'hFFFFFFF8, 32'h0, 32'hFFFFFFFF};
        send(4'b0101, 32'hF08A3715, 6'd0, 6'd0, e, 8);
        base = fire_cnt;
        t0   = cyc;
        e = '{32'hFFFFFFF0, 32'hE, 32'hC, 32'hA, 32'h8, 32'h6, 32'h4, 32'h2};
        send(4'b0101, 32'h12345678, 6'd0, 6'd1, e, 8);
        k = 0;
        while (fire_cnt < base + 16 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        if (fire_cnt < base + 16) timeout("b2b_elements");
        else chk("b2b_cycles", cyc - t0, 32'd16);
        drain();

        // Left shift by 20 of a 16-bit lane: saturates or wraps
`ifdef DCAST_SAT_EN
        e = '{32'h7FFFFFFF, 32'h00000000, 0, 0, 0, 0, 0, 0};
`else
        e = '{32'hFFF00000, 32'h00000000, 0, 0, 0, 0, 0, 0};
`endif
        send(4'b0011, 32'h00007FFF, 6'd0, 6'd20, e, 2);
        drain();

        // Pass-through shift boundaries
        e[0] = 32'h80000001;
        send(4'b0000, 32'h80000001, 6'd3, 6'd3, e, 1);
        e[0] = 32'hFFFFFFFF;
        send(4'b1111, 32'h80000000, 6'd40, 6'd0, e, 1);
        e[0] = 32'h00000000;
        send(4'b0110, 32'h7FFFFFFF, 6'd40, 6'd0, e, 1);
`ifdef DCAST_SAT_EN
        e[0] = 32'h80000000;
`else
        e[0] = 32'h00000000;
`endif
        send(4'b0000, 32'h80000000, 6'd0, 6'd32, e, 1);
`ifdef DCAST_SAT_EN
        e[0] = 32'h7FFFFFFF;
`else
        e[0] = 32'h80000000;
`endif
        send(4'b0000, 32'h00000001, 6'd0, 6'd31, e, 1);
        drain();

        // Reset mid-word after element 2 is presented
        e = '{32'h5, 32'h1, 32'h7, 32'h3, 32'hFFFFFFFA, 32'hFFFFFFF8, 32'h0, 32'hFFFFFFFF};
        send(4'b0101, 32'hF08A3715, 6'd0, 6'd0, e, 8);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_out_data", out_data, 32'h7);
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_out_data",  out_data, 32'd0);
        chk("mid_rst_out_last",  {31'b0, out_last}, 32'd0);
        chk("mid_rst_in_ready",  {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        e = '{32'hFFFFFFF0, 32'hE, 32'hC, 32'hA, 32'h8, 32'h6, 32'h4, 32'h2};
        send(4'b0101, 32'h12345678, 6'd0, 6'd1, e, 8);
        drain();

        repeat (3) @(posedge clk);
        #1;
        chk("idle_out_valid", {31'b0, out_valid}, 32'd0);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
